axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/mmu_pkg.sv | 27 ++
 rtl/axi_rd_prio.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and constants for the memory-side read path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mmu_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR_I = 3'd1,
        AR_D = 3'd2,
        R_I  = 3'd3,
        R_D  = 3'd4
    } state_t;

    // Beats per cache-line burst
    localparam int BURST_LEN_DEF = 16;

    // AXI burst types
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    // AXI arlen for a request: single-beat reads use length 0
    function automatic logic [7:0] calc_arlen(input logic single, input int burst_len);
        return single ? 8'd0 : 8'(burst_len - 1);
    endfunction

endpackage

// File: rtl/axi_rd_prio.sv
// Grant selection between inst and data requesters with inst anti-starvation.
// Latency: pick_d is combinational; data_run updates on the grant edge.
// Backpressure: none; grant_en qualifies when a pick is consumed.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_vld, d_vld  request valids from the inst / data masters
//   grant_en      high when the arbiter is taking a decision this cycle
//   pick_d        1 = data wins, 0 = inst wins (only meaningful if a valid is high)
module axi_rd_prio #(
    parameter int MAX_DATA_RUN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    input  logic d_vld,
    input  logic grant_en,
    output logic pick_d
);

    // +2 keeps the counter at least one bit wide even for MAX_DATA_RUN=0
    localparam int RW = $clog2(MAX_DATA_RUN + 2);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

    logic [RW-1:0] data_run;
    logic          starve;

    assign starve = (data_run >= RUN_MAX);
    assign pick_d = d_vld && !(i_vld && starve);

    // Only data grants that actually made inst wait count toward the run
    always_ff @(posedge clk) begin
        if (rst) begin
            data_run <= '0;
        end else if (grant_en && (i_vld || d_vld)) begin
            if (!pick_d) begin
                data_run <= '0;
            end else if (i_vld && !starve) begin
                data_run <= data_run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (inst/data) arbiter onto a single AXI read port, one burst in flight.
// Latency: request seen in IDLE -> arvalid next cycle; R data routed combinationally.
// Backpressure: req_ready mirrors arready for the granted master; rready is always 1.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req_* / i_r*                inst request and read-return channel
//   d_req_* / d_r*                data request and read-return channel
//   ar* / r*                      AXI AR and R channels toward memory
//   busy                          high whenever the FSM is not IDLE
//   len_err                       one-cycle pulse, cycle after a length mismatch or stray beat
module axi_rd_arbiter
    import mmu_pkg::*;
#(
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int MAX_DATA_RUN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_single,
    output logic        i_req_ready,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_single,
    output logic        d_req_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic        busy,
    output logic        len_err
);

    state_t      state, state_nxt;
    logic        pick_d;
    logic        in_idle;
    logic        in_r;
    logic        ar_hs;
    logic [7:0]  exp_len;
    logic [8:0]  beat_cnt;
    logic [8:0]  beat_num;
    logic [8:0]  beat_tot;

    assign in_idle  = (state == IDLE);
    assign in_r     = (state == R_I) || (state == R_D);
    assign ar_hs    = arvalid && arready;
    assign beat_num = beat_cnt + 9'd1;
    assign beat_tot = {1'b0, exp_len} + 9'd1;
    assign rready   = 1'b1;
    assign busy     = !in_idle;

    axi_rd_prio #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (i_req_valid),
        .d_vld    (d_req_valid),
        .grant_en (in_idle),
        .pick_d   (pick_d)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    state_nxt = pick_d ? AR_D : AR_I;
                end
            end
            // A requester dropping valid before the handshake abandons the grant
            AR_I: begin
                if (!i_req_valid)  state_nxt = IDLE;
                else if (arready)  state_nxt = R_I;
            end
            AR_D: begin
                if (!d_req_valid)  state_nxt = IDLE;
                else if (arready)  state_nxt = R_D;
            end
            // Only rlast ends the burst, even if the beat count already overran
            R_I, R_D: begin
                if (rvalid && rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        araddr      = '0;
        arlen       = '0;
        arburst     = '0;
        arvalid     = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        i_rdata     = '0;
        i_rvalid    = 1'b0;
        i_rlast     = 1'b0;
        d_rdata     = '0;
        d_rvalid    = 1'b0;
        d_rlast     = 1'b0;
        case (state)
            AR_I: begin
                araddr      = i_req_addr;
                arlen       = calc_arlen(i_req_single, BURST_LEN);
                arburst     = i_req_single ? BURST_FIXED : BURST_INCR;
                arvalid     = i_req_valid;
                i_req_ready = arready;
            end
            AR_D: begin
                araddr      = d_req_addr;
                arlen       = calc_arlen(d_req_single, BURST_LEN);
                arburst     = d_req_single ? BURST_FIXED : BURST_INCR;
                arvalid     = d_req_valid;
                d_req_ready = arready;
            end
            R_I: begin
                i_rdata  = rdata;
                i_rvalid = rvalid;
                i_rlast  = rlast;
            end
            R_D: begin
                d_rdata  = rdata;
                d_rvalid = rvalid;
                d_rlast  = rlast;
            end
            default: ;
        endcase
    end

    // Burst length tracking and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_len  <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (ar_hs) begin
                exp_len  <= arlen;
                beat_cnt <= '0;
            end
            if (rvalid) begin
                if (in_r) begin
                    // Saturate so a runaway burst can't wrap back to a "good" count
                    if (!(&beat_cnt)) beat_cnt <= beat_num;
                    if (rlast) begin
                        len_err <= (beat_num != beat_tot);
                    end else if (beat_num == beat_tot) begin
                        len_err <= 1'b1;
                    end
                end else begin
                    // Stray beat: not routed anywhere, flagged
                    len_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: bench acts as AXI slave, randomizing arready delay and R gaps.
module tb_axi_rd_arbiter;

    localparam int BL  = 16;
    localparam int MDR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_single, i_req_ready;
    logic [31:0] i_req_addr, i_rdata;
    logic        i_rvalid, i_rlast;
    logic        d_req_valid, d_req_single, d_req_ready;
    logic [31:0] d_req_addr, d_rdata;
    logic        d_rvalid, d_rlast;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rlast, rready;
    logic        busy, len_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: data grants made while inst waited, and the len_err expectation
    int data_run_m = 0;
    bit err_now    = 1'b0;
    bit err_next   = 1'b0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .BURST_LEN    (BL),
        .MAX_DATA_RUN (MDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_single (i_req_single),
        .i_req_ready  (i_req_ready),
        .i_rdata      (i_rdata),
        .i_rvalid     (i_rvalid),
        .i_rlast      (i_rlast),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_single (d_req_single),
        .d_req_ready  (d_req_ready),
        .d_rdata      (d_rdata),
        .d_rvalid     (d_rvalid),
        .d_rlast      (d_rlast),
        .araddr       (araddr),
        .arlen        (arlen),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rlast        (rlast),
        .rready       (rready),
        .busy         (busy),
        .len_err      (len_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sample point of a cycle: mid-cycle, after inputs settled
    task automatic settle();
        @(negedge clk);
        check("len_err", {31'd0, len_err}, {31'd0, err_now});
    endtask

    // Move to the next cycle; pulse-type slave inputs fall back to idle
    task automatic adv();
        @(posedge clk);
        #1;
        err_now  = err_next;
        err_next = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rdata    = '0;
        arready  = 1'b0;
    endtask

    // Winner rule: data unless inst has already waited MDR data grants
    task automatic model_grant(input bit iv, input bit dv, output bit data_wins);
        data_wins = dv && !(iv && data_run_m >= MDR);
        if (!data_wins)      data_run_m = 0;
        else if (iv)         data_run_m = (data_run_m + 1 > MDR) ? MDR : data_run_m + 1;
    endtask

    // One full transaction starting from IDLE
    task automatic do_txn(input bit iv, input logic [31:0] ia, input bit is_,
                          input bit dv, input logic [31:0] da, input bit ds,
                          input bit stray, input int ar_wait, input int mode, input bit gaps);
        bit          wd, ws;
        logic [31:0] waddr, dat;
        int          n, last_at;
        i_req_valid = iv; i_req_addr = ia; i_req_single = is_;
        d_req_valid = dv; d_req_addr = da; d_req_single = ds;
        if (stray) begin
            rvalid = 1'b1; rdata = $urandom; rlast = 1'($urandom_range(0, 1));
        end
        settle();
        check("idle_busy",    {31'd0, busy},        0);
        check("idle_arvalid", {31'd0, arvalid},     0);
        check("idle_irdy",    {31'd0, i_req_ready}, 0);
        check("idle_drdy",    {31'd0, d_req_ready}, 0);
        check("idle_irvalid", {31'd0, i_rvalid},    0);
        check("idle_drvalid", {31'd0, d_rvalid},    0);
        err_next = stray;
        adv();
        if (!iv && !dv) return;
        model_grant(iv, dv, wd);
        waddr = wd ? da : ia;
        ws    = wd ? ds : is_;
        for (int w = 0; w <= ar_wait; w++) begin
            arready = (w == ar_wait);
            settle();
            check("ar_busy",    {31'd0, busy},    1);
            check("arvalid",    {31'd0, arvalid}, 1);
            check("araddr",     araddr,           waddr);
            check("arlen",      {24'd0, arlen},   ws ? 0 : BL - 1);
            check("arburst",    {30'd0, arburst}, ws ? 0 : 1);
            check("win_ready",  {31'd0, wd ? d_req_ready : i_req_ready}, {31'd0, arready});
            check("lose_ready", {31'd0, wd ? i_req_ready : d_req_ready}, 0);
            adv();
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        n = ws ? 1 : BL;
        case (mode)
            1:       last_at = (n > 1) ? int'($urandom_range(1, n - 1)) : n;
            2:       last_at = n + int'($urandom_range(1, 3));
            default: last_at = n;
        endcase
        for (int k = 1; k <= last_at; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                settle();
                check("gap_rvalid", {31'd0, wd ? d_rvalid : i_rvalid}, 0);
                check("gap_busy",   {31'd0, busy}, 1);
                adv();
            end
            dat = $urandom;
            rvalid = 1'b1; rdata = dat; rlast = (k == last_at);
            settle();
            check("win_rvalid",  {31'd0, wd ? d_rvalid : i_rvalid}, 1);
            check("win_rdata",   wd ? d_rdata : i_rdata, dat);
            check("win_rlast",   {31'd0, wd ? d_rlast : i_rlast}, {31'd0, k == last_at});
            check("lose_rvalid", {31'd0, wd ? i_rvalid : d_rvalid}, 0);
            check("lose_rdata",  wd ? i_rdata : d_rdata, 0);
            check("r_busy",      {31'd0, busy}, 1);
            err_next = (k == last_at) ? (k != n) : (k == n);
            adv();
        end
    endtask

    // Requester drops valid while waiting for arready
    task automatic viol_txn();
        bit wd;
        i_req_valid = 1'b1; i_req_addr = $urandom; i_req_single = 1'b0;
        settle();
        adv();
        model_grant(1'b1, 1'b0, wd);
        i_req_valid = 1'b0;
        settle();
        check("viol_busy",    {31'd0, busy},        1);
        check("viol_arvalid", {31'd0, arvalid},     0);
        check("viol_irdy",    {31'd0, i_req_ready}, 0);
        adv();
        settle();
        check("viol_idle", {31'd0, busy}, 0);
        adv();
    endtask

    // Reset in the middle of an inst burst, then stray beats
    task automatic rst_mid_burst();
        bit wd;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1000; i_req_single = 1'b0;
        settle();
        adv();
        model_grant(1'b1, 1'b0, wd);
        arready = 1'b1;
        settle();
        adv();
        i_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rvalid = 1'b1; rdata = $urandom;
            settle();
            check("pre_rst_rvalid", {31'd0, i_rvalid}, 1);
            adv();
        end
        rvalid = 1'b1; rdata = $urandom; rst = 1'b1;
        settle();
        adv();
        rst = 1'b0;
        err_now = 1'b0;
        data_run_m = 0;
        for (int k = 6; k <= 9; k++) begin
            rvalid = 1'b1; rdata = $urandom; rlast = (k == 9);
            settle();
            check("rst_busy",     {31'd0, busy},     0);
            check("rst_arvalid",  {31'd0, arvalid},  0);
            check("rst_irvalid",  {31'd0, i_rvalid}, 0);
            check("rst_drvalid",  {31'd0, d_rvalid}, 0);
            err_next = 1'b1;
            adv();
        end
        settle();
        adv();
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0; i_req_single = 1'b0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_single = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check("rst_busy0",    {31'd0, busy},        0);
        check("rst_arvalid0", {31'd0, arvalid},     0);
        check("rst_irdy0",    {31'd0, i_req_ready}, 0);
        check("rst_drdy0",    {31'd0, d_req_ready}, 0);
        check("rst_irv0",     {31'd0, i_rvalid},    0);
        check("rst_drv0",     {31'd0, d_rvalid},    0);
        check("rready",       {31'd0, rready},      1);
        adv();

        // Inst single read, immediate arready
        do_txn(1'b1, 32'h1FC0_0000, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
        // Both valid three times: grant order D, D, I
        for (int t = 0; t < 3; t++)
            do_txn(1'b1, 32'h1FC0_0100, 1'b0, 1'b1, 32'h8000_0040 + 32'(t) * 64, 1'b0, 1'b0, 0, 0, 1'b0);
        // Long arready stall
        do_txn(1'b0, '0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 1'b0, 10, 0, 1'b0);
        // Early and late rlast on full bursts
        do_txn(1'b0, '0, 1'b0, 1'b1, 32'h8000_2000, 1'b0, 1'b0, 0, 1, 1'b0);
        do_txn(1'b1, 32'h1FC0_0200, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 2, 1'b0);
        // Stray beat in IDLE with nobody requesting
        do_txn(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 0, 0, 1'b0);
        viol_txn();
        rst_mid_burst();

        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                   1'($urandom_range(0, 1)));
        end

        settle();
        adv();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
